// File: rtl/ppu_scroll_cntr.sv
// Loopy-style VRAM address / scroll counter: latch loads, CPU $2007 increments, per-dot render stepping.
// Optional PPU_SCROLL_GLITCH_EN: $2007 access during rendering performs coarse-X + fine-Y increments.
module ppu_scroll_cntr #(
   parameter int PRE_LINE  = 261,
   parameter int VIS_LINES = 240
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [2:0]  fv_in,
   input  logic [4:0]  vt_in,
   input  logic        v_in,
   input  logic [2:0]  fh_in,
   input  logic [4:0]  ht_in,
   input  logic        h_in,
   input  logic        upd_cntrs_in,
   input  logic        inc_addr_in,
   input  logic        inc_addr_amt_in,
   input  logic        bg_en_in,
   input  logic        dot_pulse_in,
   input  logic [8:0]  x_in,
   input  logic [8:0]  y_in,
   output logic [13:0] vram_a_out,
   output logic [13:0] nt_a_out,
   output logic [13:0] at_a_out,
   output logic [2:0]  fine_x_out
);

   localparam logic [8:0] PRE_L = 9'(PRE_LINE);
   localparam logic [8:0] VIS_L = 9'(VIS_LINES);

   // cnt layout: [14:12] fv, [11] v, [10] h, [9:5] vt, [4:0] ht
   logic [14:0] cnt_q, cnt_d;
   logic [2:0]  fine_x_q, fine_x_d;
   logic [14:0] step_c;
   logic        rend_active;
   logic        cx_dot;
   logic        vreload_dot;

   function automatic logic [14:0] inc_cx(input logic [14:0] c);
      logic [14:0] r;
      r = c;
      if (c[4:0] == 5'd31) begin
         r[4:0] = 5'd0;
         r[10]  = ~c[10];
      end else begin
         r[4:0] = c[4:0] + 5'd1;
      end
      return r;
   endfunction

   // Row 29 is the last nametable row; rows 30/31 (attribute space) wrap without switching tables.
   function automatic logic [14:0] inc_fy(input logic [14:0] c);
      logic [14:0] r;
      r = c;
      if (c[14:12] != 3'd7) begin
         r[14:12] = c[14:12] + 3'd1;
      end else begin
         r[14:12] = 3'd0;
         if (c[9:5] == 5'd29) begin
            r[9:5] = 5'd0;
            r[11]  = ~c[11];
         end else if (c[9:5] == 5'd31) begin
            r[9:5] = 5'd0;
         end else begin
            r[9:5] = c[9:5] + 5'd1;
         end
      end
      return r;
   endfunction

   assign rend_active = bg_en_in & ((y_in < VIS_L) | (y_in == PRE_L));
   assign cx_dot      = ((x_in[2:0] == 3'd0) && (x_in >= 9'd8) && (x_in <= 9'd256)) ||
                        (x_in == 9'd328) || (x_in == 9'd336);
   assign vreload_dot = (y_in == PRE_L) && (x_in >= 9'd280) && (x_in <= 9'd304);

   always_comb begin
      step_c = cnt_q;
      if (cx_dot)           step_c = inc_cx(step_c);
      if (x_in == 9'd256)   step_c = inc_fy(step_c);
      if (x_in == 9'd257) begin
         step_c[10]  = h_in;
         step_c[4:0] = ht_in;
      end
      if (vreload_dot) begin
         step_c[14:12] = fv_in;
         step_c[11]    = v_in;
         step_c[9:5]   = vt_in;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      fine_x_d = fine_x_q;
      if (upd_cntrs_in) begin
         cnt_d    = {fv_in, v_in, h_in, vt_in, ht_in};
         fine_x_d = fh_in;
      end else if (inc_addr_in) begin
         if (!rend_active) begin
            cnt_d = cnt_q + (inc_addr_amt_in ? 15'd32 : 15'd1);
         end else begin
`ifdef PPU_SCROLL_GLITCH_EN
            cnt_d = inc_fy(inc_cx(cnt_q));
`else
            cnt_d = cnt_q;
`endif
         end
      end else if (dot_pulse_in && rend_active) begin
         cnt_d = step_c;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q    <= '0;
         fine_x_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         fine_x_q <= fine_x_d;
      end
   end

   assign vram_a_out = cnt_q[13:0];
   assign nt_a_out   = {2'b10, cnt_q[11:0]};
   assign at_a_out   = {2'b10, cnt_q[11], cnt_q[10], 4'b1111, cnt_q[9:7], cnt_q[4:2]};
   assign fine_x_out = fine_x_q;

endmodule

// File: tb/tb_ppu_scroll_cntr.sv
// Self-checking bench for ppu_scroll_cntr: expected addresses queued at stimulus, compared after the edge.
module tb_ppu_scroll_cntr;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [2:0]  fv_in, fh_in;
   logic [4:0]  vt_in, ht_in;
   logic        v_in, h_in;
   logic        upd_cntrs_in, inc_addr_in, inc_addr_amt_in, bg_en_in, dot_pulse_in;
   logic [8:0]  x_in, y_in;
   logic [13:0] vram_a_out, nt_a_out, at_a_out;
   logic [2:0]  fine_x_out;

   typedef struct {
      string       tag;
      logic [13:0] vram;
      logic [2:0]  fx;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic [2:0]  exp_fx = 3'd0;
   logic [14:0] model;

   ppu_scroll_cntr dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .fv_in(fv_in), .vt_in(vt_in), .v_in(v_in),
      .fh_in(fh_in), .ht_in(ht_in), .h_in(h_in),
      .upd_cntrs_in(upd_cntrs_in), .inc_addr_in(inc_addr_in), .inc_addr_amt_in(inc_addr_amt_in),
      .bg_en_in(bg_en_in), .dot_pulse_in(dot_pulse_in), .x_in(x_in), .y_in(y_in),
      .vram_a_out(vram_a_out), .nt_a_out(nt_a_out), .at_a_out(at_a_out), .fine_x_out(fine_x_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Push expectation, clock once, pop and compare; pulses are cleared afterwards.
   task automatic tick(input string tag, input logic [13:0] vram);
      exp_t e;
      exp_q.push_back('{tag: tag, vram: vram, fx: exp_fx});
      @(posedge clk_in);
      #1;
      e = exp_q.pop_front();
      chk({e.tag, ".vram"}, {2'b0, vram_a_out}, {2'b0, e.vram});
      chk({e.tag, ".nt"}, {2'b0, nt_a_out}, {4'b0010, e.vram[11:0]});
      chk({e.tag, ".fx"}, {13'b0, fine_x_out}, {13'b0, e.fx});
      upd_cntrs_in = 0; inc_addr_in = 0; dot_pulse_in = 0;
   endtask

   task automatic load(input logic [2:0] fv, input logic v, input logic h,
                       input logic [4:0] vt, input logic [4:0] ht, input logic [2:0] fh,
                       input logic [13:0] vram, input string tag);
      fv_in = fv; v_in = v; h_in = h; vt_in = vt; ht_in = ht; fh_in = fh;
      upd_cntrs_in = 1;
      exp_fx = fh;
      tick(tag, vram);
   endtask

   task automatic dot(input logic [8:0] x, input logic [8:0] y, input logic [13:0] vram, input string tag);
      x_in = x; y_in = y; dot_pulse_in = 1;
      tick(tag, vram);
   endtask

   initial begin
      rst_n_in = 0;
      {fv_in, fh_in, vt_in, ht_in, v_in, h_in} = '0;
      {upd_cntrs_in, inc_addr_in, inc_addr_amt_in, bg_en_in, dot_pulse_in} = '0;
      x_in = 0; y_in = 0;
      #1;
      chk("rst.vram", {2'b0, vram_a_out}, 16'h0000);
      chk("rst.nt",   {2'b0, nt_a_out},   16'h2000);
      chk("rst.at",   {2'b0, at_a_out},   16'h23C0);
      chk("rst.fx",   {13'b0, fine_x_out}, 16'h0000);
      @(negedge clk_in);
      rst_n_in = 1;

      // latch load
      load(3'd0, 1'b1, 1'b0, 5'h10, 5'h05, 3'd3, 14'h0A05, "load");
      chk("load.at", {2'b0, at_a_out}, 16'h2BE1);

      // CPU increment wrap into fv[2], then +32
      load(3'd3, 1'b1, 1'b1, 5'd31, 5'd31, 3'd3, 14'h3FFF, "ld3fff");
      inc_addr_in = 1; inc_addr_amt_in = 0; tick("inc1", 14'h0000);
      inc_addr_in = 1; inc_addr_amt_in = 1; tick("inc32", 14'h0020);

      // coarse-X with nametable toggle, then horizontal reload at 257
      bg_en_in = 1;
      load(3'd0, 1'b0, 1'b0, 5'd0, 5'd31, 3'd1, 14'h001F, "ldcx");
      x_in = 9'd8; y_in = 9'd10; tick("nodot", 14'h001F);
      dot(9'd8, 9'd10, 14'h0400, "cx8");
      dot(9'd9, 9'd10, 14'h0400, "cx9");
      ht_in = 5'd5; h_in = 1'b1;
      dot(9'd257, 9'd10, 14'h0405, "hrl257");
      dot(9'd264, 9'd10, 14'h0405, "cx264");
      dot(9'd336, 9'd10, 14'h0406, "cx336");

      // fine-Y overflow: row 29 switches nametable, row 31 does not; coarse-X also steps at 256
      load(3'd7, 1'b0, 1'b0, 5'd29, 5'd0, 3'd1, 14'h33A0, "ldfy29");
      dot(9'd256, 9'd10, 14'h0801, "fy29");
      load(3'd7, 1'b0, 1'b0, 5'd31, 5'd0, 3'd1, 14'h33E0, "ldfy31");
      dot(9'd256, 9'd10, 14'h0001, "fy31");
      load(3'd2, 1'b0, 1'b0, 5'd3, 5'd4, 3'd1, 14'h2064, "ldfy");
      dot(9'd256, 9'd239, 14'h3065, "fy239");
      dot(9'd8, 9'd240, 14'h3065, "y240");
      bg_en_in = 0;
      dot(9'd8, 9'd10, 14'h3065, "bgoff");
      bg_en_in = 1;

      // latch load beats same-cycle step
      fv_in = 0; v_in = 0; h_in = 0; vt_in = 0; ht_in = 5'd3; fh_in = 3'd6;
      upd_cntrs_in = 1; x_in = 9'd8; y_in = 9'd10; dot_pulse_in = 1; exp_fx = 3'd6;
      tick("updwins", 14'h0003);

      // pre-render vertical reload window
      fv_in = 3'd5; v_in = 1; h_in = 1; vt_in = 5'd7; ht_in = 5'd9;
      dot(9'd279, 9'd261, 14'h0003, "pre279");
      dot(9'd280, 9'd261, 14'h18E3, "pre280");
      fv_in = 3'd1; vt_in = 5'd2; v_in = 0;
      dot(9'd304, 9'd261, 14'h1043, "pre304");
      fv_in = 3'd6;
      dot(9'd305, 9'd261, 14'h1043, "pre305");

      // $2007 access during rendering
      load(3'd7, 1'b0, 1'b0, 5'd29, 5'd0, 3'd6, 14'h33A0, "ldgl");
      x_in = 9'd100; y_in = 9'd10; inc_addr_in = 1; inc_addr_amt_in = 1;
`ifdef PPU_SCROLL_GLITCH_EN
      tick("glitch", 14'h0801);
`else
      tick("noglitch", 14'h33A0);
      inc_addr_in = 1; x_in = 9'd8; dot_pulse_in = 1;
      tick("incdrop", 14'h33A0);
`endif

      // random CPU increments outside rendering against a 15-bit model
      bg_en_in = 0;
      load(3'd6, 1'b1, 1'b0, 5'd30, 5'd27, 3'd2, 14'h2BDB, "ldrnd");
      model = 15'h6BDB;
      for (int i = 0; i < 24; i++) begin
         inc_addr_in = 1;
         inc_addr_amt_in = 1'($urandom_range(0, 1));
         model = model + (inc_addr_amt_in ? 15'd32 : 15'd1);
         tick("rndinc", model[13:0]);
      end

      // asynchronous reset mid-frame, then stepping resumes
      bg_en_in = 1;
      #2 rst_n_in = 0;
      #1;
      chk("mrst.vram", {2'b0, vram_a_out}, 16'h0000);
      chk("mrst.at",   {2'b0, at_a_out},   16'h23C0);
      chk("mrst.fx",   {13'b0, fine_x_out}, 16'h0000);
      exp_fx = 3'd0;
      @(negedge clk_in);
      rst_n_in = 1;
      dot(9'd16, 9'd0, 14'h0001, "postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
